// File: rtl/decode_stage_pipelined_if.sv
// Decode-stage bus: decode control, writeback port and ID/EX outputs.
interface decode_stage_pipelined_if #(
    parameter int WIDTH        = 32,
    parameter int ADDRESSWIDTH = 4
);
    logic                    inValid;
    logic                    stall;
    logic                    flush;
    logic [ADDRESSWIDTH-1:0] reg1Address;
    logic [ADDRESSWIDTH-1:0] reg2Address;
    logic [ADDRESSWIDTH-1:0] destAddress;
    logic [WIDTH-1:0]        inmmediate;
    logic                    useImmediate;
    logic                    obtainPCAsR1;
    logic [WIDTH-1:0]        PCPlus8;
    logic                    writeEnable;
    logic [ADDRESSWIDTH-1:0] writeAddress;
    logic [WIDTH-1:0]        dataToSave;
    logic                    outValid;
    logic [WIDTH-1:0]        operandA;
    logic [WIDTH-1:0]        operandB;
    logic [WIDTH-1:0]        storeData;
    logic [ADDRESSWIDTH-1:0] outDestAddress;

    modport master (
        output inValid, stall, flush, reg1Address, reg2Address, destAddress,
               inmmediate, useImmediate, obtainPCAsR1, PCPlus8,
               writeEnable, writeAddress, dataToSave,
        input  outValid, operandA, operandB, storeData, outDestAddress
    );

    modport slave (
        input  inValid, stall, flush, reg1Address, reg2Address, destAddress,
               inmmediate, useImmediate, obtainPCAsR1, PCPlus8,
               writeEnable, writeAddress, dataToSave,
        output outValid, operandA, operandB, storeData, outDestAddress
    );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Decode stage: register file with write-through bypass, operand muxing
// (PC+8 on A, immediate on B) and an ID/EX register with stall/flush.
module decode_stage_pipelined #(
    parameter int WIDTH        = 32,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    decode_stage_pipelined_if.slave bus
);
    // One extra bit so REGNUM == 2**ADDRESSWIDTH is representable.
    localparam logic [ADDRESSWIDTH:0] REGNUM_W = (ADDRESSWIDTH + 1)'(REGNUM);

    logic [WIDTH-1:0]        r_regs [REGNUM];
    logic                    r_valid;
    logic [WIDTH-1:0]        r_op_a;
    logic [WIDTH-1:0]        r_op_b;
    logic [WIDTH-1:0]        r_store;
    logic [ADDRESSWIDTH-1:0] r_dest;

    logic             w_wr_ok;
    logic             w_rd1_ok;
    logic             w_rd2_ok;
    logic [WIDTH-1:0] w_rd1;
    logic [WIDTH-1:0] w_rd2;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;

    assign w_wr_ok  = bus.writeEnable && ({1'b0, bus.writeAddress} < REGNUM_W);
    assign w_rd1_ok = {1'b0, bus.reg1Address} < REGNUM_W;
    assign w_rd2_ok = {1'b0, bus.reg2Address} < REGNUM_W;

    // Read ports: out-of-range reads 0; a same-cycle write to the address wins.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_rd1_ok) begin
            if (w_wr_ok && (bus.writeAddress == bus.reg1Address))
                w_rd1 = bus.dataToSave;
            else
                w_rd1 = r_regs[bus.reg1Address];
        end
        if (w_rd2_ok) begin
            if (w_wr_ok && (bus.writeAddress == bus.reg2Address))
                w_rd2 = bus.dataToSave;
            else
                w_rd2 = r_regs[bus.reg2Address];
        end
    end

    assign w_sel_a = bus.obtainPCAsR1 ? bus.PCPlus8    : w_rd1;
    assign w_sel_b = bus.useImmediate ? bus.inmmediate : w_rd2;

    // Register file write port, independent of stall/flush/inValid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGNUM; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[bus.writeAddress] <= bus.dataToSave;
        end
    end

    // ID/EX register: flush beats stall beats load; held entries are not refreshed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_store <= '0;
            r_dest  <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_store <= '0;
            r_dest  <= '0;
        end else if (!bus.stall) begin
            r_valid <= bus.inValid;
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_store <= w_rd2;
            r_dest  <= bus.destAddress;
        end
    end

    assign bus.outValid       = r_valid;
    assign bus.operandA       = r_op_a;
    assign bus.operandB       = r_op_b;
    assign bus.storeData      = r_store;
    assign bus.outDestAddress = r_dest;
endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Bench for decode_stage_pipelined: directed scenarios plus random traffic
// against a behavioural model; a second instance with REGNUM=12.
module tb_decode_stage_pipelined;
    localparam int REGN = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    decode_stage_pipelined_if #(.WIDTH(32), .ADDRESSWIDTH(4)) bus ();
    decode_stage_pipelined_if #(.WIDTH(32), .ADDRESSWIDTH(4)) bus12 ();

    decode_stage_pipelined #(.WIDTH(32), .REGNUM(16), .ADDRESSWIDTH(4)) dut (
        .clock(clock), .reset(reset), .bus(bus));
    decode_stage_pipelined #(.WIDTH(32), .REGNUM(12), .ADDRESSWIDTH(4)) dut12 (
        .clock(clock), .reset(reset), .bus(bus12));

    // Behavioural model of the 16-entry instance
    logic [31:0] m_regs [REGN];
    logic        m_valid;
    logic [31:0] m_a, m_b, m_sd;
    logic [3:0]  m_dest;

    function automatic logic [31:0] mread(input logic [3:0] a);
        if (int'(a) >= REGN) return 32'h0;
        if (bus.writeEnable && bus.writeAddress == a) return bus.dataToSave;
        return m_regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < REGN; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0; m_a = 0; m_b = 0; m_sd = 0; m_dest = 0;
    endtask

    // Advance one clock edge and update the model with what the edge does.
    task automatic tick();
        logic [31:0] na, nb, nsd;
        na  = bus.obtainPCAsR1 ? bus.PCPlus8 : mread(bus.reg1Address);
        nb  = bus.useImmediate ? bus.inmmediate : mread(bus.reg2Address);
        nsd = mread(bus.reg2Address);
        @(posedge clock);
        if (reset) begin
            if (bus.flush) begin
                m_valid = 1'b0; m_a = 0; m_b = 0; m_sd = 0; m_dest = 0;
            end else if (!bus.stall) begin
                m_valid = bus.inValid; m_a = na; m_b = nb; m_sd = nsd;
                m_dest = bus.destAddress;
            end
            if (bus.writeEnable && int'(bus.writeAddress) < REGN)
                m_regs[bus.writeAddress] = bus.dataToSave;
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic idle();
        bus.inValid = 0; bus.stall = 0; bus.flush = 0;
        bus.reg1Address = 0; bus.reg2Address = 0; bus.destAddress = 0;
        bus.inmmediate = 0; bus.useImmediate = 0; bus.obtainPCAsR1 = 0;
        bus.PCPlus8 = 0; bus.writeEnable = 0; bus.writeAddress = 0; bus.dataToSave = 0;
    endtask

    task automatic idle12();
        bus12.inValid = 0; bus12.stall = 0; bus12.flush = 0;
        bus12.reg1Address = 0; bus12.reg2Address = 0; bus12.destAddress = 0;
        bus12.inmmediate = 0; bus12.useImmediate = 0; bus12.obtainPCAsR1 = 0;
        bus12.PCPlus8 = 0; bus12.writeEnable = 0; bus12.writeAddress = 0; bus12.dataToSave = 0;
    endtask

    task automatic randomize_inputs();
        bus.inValid = 1'($urandom); bus.reg1Address = 4'($urandom);
        bus.reg2Address = 4'($urandom); bus.destAddress = 4'($urandom);
        bus.inmmediate = $urandom; bus.useImmediate = 1'($urandom);
        bus.obtainPCAsR1 = 1'($urandom); bus.PCPlus8 = $urandom;
        bus.writeEnable = 1'($urandom); bus.writeAddress = 4'($urandom);
        bus.dataToSave = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            randomize_inputs();
            bus.stall = 1'($urandom); bus.flush = 1'($urandom);
            tick();
            total++;
            if ({bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress} !== '0) begin
                bad++;
                $display("FAIL reset_hold: valid=%0b a=%h b=%h sd=%h dest=%h required all 0",
                         bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress);
            end
        end
        idle();
        reset = 1'b1;
        for (int i = 0; i < REGN; i++) begin
            bus.reg1Address = 4'(i); bus.reg2Address = 4'((i + 1) % REGN);
            tick();
            total++;
            if (bus.operandA !== 32'h0 || bus.storeData !== 32'h0) begin
                bad++;
                $display("FAIL reset_regfile r%0d: a=%h sd=%h required 0", i, bus.operandA, bus.storeData);
            end
        end
    endtask

    task automatic test_write_read();
        idle();
        bus.writeEnable = 1; bus.writeAddress = 3; bus.dataToSave = 32'hDEADBEEF;
        tick();
        idle();
        bus.reg1Address = 3; bus.inValid = 1; bus.destAddress = 4'hA;
        tick();
        total++;
        if (bus.operandA !== 32'hDEADBEEF || bus.outValid !== 1'b1 || bus.outDestAddress !== 4'hA) begin
            bad++;
            $display("FAIL write_read: a=%h valid=%0b dest=%h required DEADBEEF 1 a",
                     bus.operandA, bus.outValid, bus.outDestAddress);
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.writeEnable = 1; bus.writeAddress = 5; bus.dataToSave = 32'h12345678;
        bus.reg2Address = 5; bus.inValid = 1;
        tick();
        total++;
        if (bus.operandB !== 32'h12345678 || bus.storeData !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass: b=%h sd=%h required 12345678", bus.operandB, bus.storeData);
        end
    endtask

    task automatic test_substitution();
        idle();
        bus.inValid = 1; bus.obtainPCAsR1 = 1; bus.PCPlus8 = 32'h108; bus.reg1Address = 5;
        bus.useImmediate = 1; bus.inmmediate = 32'hFF; bus.reg2Address = 3;
        tick();
        total++;
        if (bus.operandA !== 32'h108 || bus.operandB !== 32'hFF || bus.storeData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL substitution: a=%h b=%h sd=%h required 108 ff deadbeef",
                     bus.operandA, bus.operandB, bus.storeData);
        end
    endtask

    task automatic test_stall_flush();
        idle();
        bus.inValid = 1; bus.reg1Address = 3; bus.reg2Address = 5; bus.destAddress = 7;
        tick();
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            bus.stall = 1;
            bus.writeEnable = (c == 1);
            bus.writeAddress = 9; bus.dataToSave = 32'hCAFEF00D;
            tick();
            total++;
            if (bus.outValid !== 1'b1 || bus.operandA !== 32'hDEADBEEF || bus.operandB !== 32'h12345678 ||
                bus.storeData !== 32'h12345678 || bus.outDestAddress !== 4'h7) begin
                bad++;
                $display("FAIL stall_hold c%0d: v=%0b a=%h b=%h sd=%h d=%h required 1 deadbeef 12345678 12345678 7",
                         c, bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress);
            end
        end
        randomize_inputs();
        bus.writeEnable = 0; bus.stall = 1; bus.flush = 1; bus.inValid = 1;
        tick();
        total++;
        if ({bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress} !== '0) begin
            bad++;
            $display("FAIL stall_flush: v=%0b a=%h b=%h sd=%h d=%h required all 0",
                     bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress);
        end
        idle();
        bus.reg1Address = 9; bus.inValid = 1;
        tick();
        total++;
        if (bus.operandA !== 32'hCAFEF00D || bus.outValid !== 1'b1) begin
            bad++;
            $display("FAIL write_during_stall: a=%h v=%0b required cafef00d 1", bus.operandA, bus.outValid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) bus.reg1Address = bus.writeAddress;
            if ($urandom_range(0, 3) == 0) bus.reg2Address = bus.writeAddress;
            tick();
            total++;
            if (bus.outValid !== m_valid || bus.outDestAddress !== m_dest) begin
                bad++;
                $display("FAIL random_ctl c%0d: v=%0b d=%h required %0b %h",
                         c, bus.outValid, bus.outDestAddress, m_valid, m_dest);
            end
            total++;
            if (bus.operandA !== m_a || bus.operandB !== m_b || bus.storeData !== m_sd) begin
                bad++;
                $display("FAIL random_data c%0d: a=%h b=%h sd=%h required %h %h %h",
                         c, bus.operandA, bus.operandB, bus.storeData, m_a, m_b, m_sd);
            end
        end
    endtask

    task automatic test_out_of_range();
        idle12();
        bus12.writeEnable = 1; bus12.writeAddress = 11; bus12.dataToSave = 32'h11111111;
        tick();
        bus12.writeAddress = 14; bus12.dataToSave = 32'hAAAA5555;
        bus12.reg1Address = 14; bus12.reg2Address = 11; bus12.inValid = 1;
        tick();
        total++;
        if (bus12.operandA !== 32'h0 || bus12.storeData !== 32'h11111111) begin
            bad++;
            $display("FAIL oor_bypass: a=%h sd=%h required 0 11111111", bus12.operandA, bus12.storeData);
        end
        bus12.writeEnable = 0; bus12.reg2Address = 14;
        tick();
        total++;
        if (bus12.operandA !== 32'h0 || bus12.storeData !== 32'h0 || bus12.outValid !== 1'b1) begin
            bad++;
            $display("FAIL oor_read: a=%h sd=%h v=%0b required 0 0 1",
                     bus12.operandA, bus12.storeData, bus12.outValid);
        end
        idle12();
    endtask

    task automatic test_midop_reset();
        idle();
        bus.writeEnable = 1; bus.writeAddress = 3; bus.dataToSave = 32'h5A5A5A5A;
        tick();
        idle();
        bus.inValid = 1; bus.reg1Address = 3; bus.reg2Address = 3; bus.destAddress = 2;
        tick();
        total++;
        if (bus.outValid !== 1'b1 || bus.operandA !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL midop_preload: v=%0b a=%h required 1 5a5a5a5a", bus.outValid, bus.operandA);
        end
        #2 reset = 1'b0;
        #1;
        model_clear();
        total++;
        if ({bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress} !== '0) begin
            bad++;
            $display("FAIL midop_reset: v=%0b a=%h b=%h sd=%h d=%h required all 0",
                     bus.outValid, bus.operandA, bus.operandB, bus.storeData, bus.outDestAddress);
        end
        #1 reset = 1'b1;
        tick();
        total++;
        if (bus.operandA !== 32'h0 || bus.storeData !== 32'h0 || bus.outValid !== 1'b1) begin
            bad++;
            $display("FAIL midop_regfile: a=%h sd=%h v=%0b required 0 0 1",
                     bus.operandA, bus.storeData, bus.outValid);
        end
    endtask

    initial begin
        model_clear();
        idle();
        idle12();
        test_reset();
        test_write_read();
        test_bypass();
        test_substitution();
        test_stall_flush();
        test_random();
        test_out_of_range();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised decode stage: multi-entry register file (one write port, two read ports) with same-cycle write-through bypass, PC+8 substitution on operand A, and immediate substitution on operand B. Operands are registered into an ID/EX pipeline register with a valid bit, stall (hold) and flush (bubble) control. Sits between fetch/decode control and execute; the writeback stage drives the write port.

Parameters:
WIDTH, 32, data width of registers, immediate, PC and operands
REGNUM, 16, number of implemented registers (must be <= 2**ADDRESSWIDTH)
ADDRESSWIDTH, 4, width of every register address

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
inValid  input  1  decode slot holds a real instruction
stall  input  1  hold ID/EX register contents this cycle
flush  input  1  insert bubble into ID/EX this cycle
reg1Address  input  ADDRESSWIDTH  read port 1 address
reg2Address  input  ADDRESSWIDTH  read port 2 address
destAddress  input  ADDRESSWIDTH  instruction destination, passed down pipe
inmmediate  input  WIDTH  extended immediate
useImmediate  input  1  operandB takes inmmediate instead of reg2 content
obtainPCAsR1  input  1  operandA takes PCPlus8 instead of reg1 content
PCPlus8  input  WIDTH  PC+8 of decoding instruction
writeEnable  input  1  writeback write strobe
writeAddress  input  ADDRESSWIDTH  writeback address
dataToSave  input  WIDTH  writeback data
outValid  output  1  ID/EX entry valid
operandA  output  WIDTH  registered operand A
operandB  output  WIDTH  registered operand B
storeData  output  WIDTH  registered reg2 content (always register, never immediate)
outDestAddress  output  ADDRESSWIDTH  registered destination

Behaviour:
- Reset (reset==0, asynchronous): all REGNUM registers = 0; outValid=0; operandA, operandB, storeData, outDestAddress = 0. Held while reset low; first capture on first rising edge after release.
- Register file write: on rising edge when writeEnable==1 and writeAddress < REGNUM; writeAddress >= REGNUM ignored. Writes happen regardless of stall/flush/inValid.
- Read: combinational. Address >= REGNUM reads 0. Bypass: if writeEnable==1 and writeAddress==readAddress (< REGNUM), read returns dataToSave in that same cycle.
- Operand select: A = obtainPCAsR1 ? PCPlus8 : read1; B = useImmediate ? inmmediate : read2; storeData source = read2 (bypassed).
- ID/EX register, per rising edge, priority flush > stall > load:
  - flush==1: outValid<=0, operandA/operandB/storeData/outDestAddress<=0.
  - else stall==1: all outputs hold previous values (including outValid).
  - else: outValid<=inValid; data outputs load selected values (loaded even if inValid==0).
- Latency: 1 cycle from decode inputs to outputs. Throughput: 1 instruction/cycle when not stalled.
- Stall and flush together: flush wins.
- Stalled entry is not refreshed by later writebacks; forwarding for held operands belongs to execute.
- Reset asserted mid-operation: outputs and register file clear immediately, independent of clock.
- All widths equal; no arithmetic, no truncation.

Test Plan:
- Reset: hold reset=0 with random inputs -> outValid=0, all outputs 0; after release, reading r0..r15 gives 0.
- Write then read: write r3=0xDEADBEEF; next cycle reg1Address=3, inValid=1 -> one edge later operandA=0xDEADBEEF, outValid=1.
- Bypass: same cycle writeEnable=1, writeAddress=5, dataToSave=0x12345678, reg2Address=5, useImmediate=0 -> next edge operandB=storeData=0x12345678.
- Substitution: obtainPCAsR1=1, PCPlus8=0x108, useImmediate=1, inmmediate=0xFF, reg2Address=3 (0xDEADBEEF) -> operandA=0x108, operandB=0xFF, storeData=0xDEADBEEF.
- Stall/flush: load valid entry, then stall=1 for 3 cycles with changing inputs -> outputs constant; stall=1 and flush=1 same cycle -> outValid=0, data 0; writeback during stall still updates the register file (readable afterwards).
- Mid-op reset and out-of-range: with outValid=1, drop reset between edges -> outputs 0 immediately; with REGNUM=12, write address 14 ignored and read of 14 returns 0.
